dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-requester arbiter and sequencer in front of the single-ported data memory (combinational read, write on rising clock edge). Port A is the pipeline's memory stage and Port B is a DMA/debug master; both share the same memory. The block grants one owner at a time, with round-robin fairness and bounded Port B bursts. It routes the owner's address, data, width and sign controls to the memory, and returns per-port acknowledge and read data.

## Interface
- MAX_BURST, 8: maximum Port B beats per grant (≥1).
- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  synchronous, active-low; 0 at a rising edge resets all state.
- a_req  in  1  Port A access request; a_addr/a_wd/a_we/a_width/a_signed/a_pc held stable until a_ack.
- a_addr  in  32  byte address.
- a_wd  in  32  write data.
- a_we  in  1  1 = write, 0 = read.
- a_width  in  2  00 word, 01 half, 10 byte.
- a_signed  in  1  sign-extend sub-word loads.
- a_pc  in  32  PC of the issuing instruction, forwarded for the write log.
- a_ack  out  1  access performed this cycle.
- a_rd  out  32  load data, valid when a_ack & ~a_we, else 0.
- b_req, b_addr[32], b_wd[32], b_we, b_width[2], b_signed  in  Port B equivalents.
- b_last  in  1  current beat is the final beat of the B burst.
- b_ack  out  1  access performed this cycle.
- b_rd  out  32  load data, valid when b_ack & ~b_we, else 0.
- dm_addr  out  32  address to memory.
- dm_wd  out  32  write data to memory.
- dm_we  out  1  write enable to memory.
- dm_width  out  2  width code to memory.
- dm_signed  out  1  sign control to memory.
- dm_wpc  out  32  write-log PC; a_pc when A owns, 0 when B owns.
- dm_rd  in  32  memory read data.

## Operation
- States:
  - IDLE: no owner. All dm_* outputs 0; no ack.
  - OWN_A: A owns the memory.
  - OWN_B: B owns the memory.
- Ack rules:
  - a_ack = (state==OWN_A) & a_req.
  - b_ack = (state==OWN_B) & b_req.
  - dm_we = ack & owner's we. A write never reaches memory without an ack.
- Routing: dm_* = owner's fields in OWN_x, zero in IDLE. Width and sign pass through unmodified.
- last_owner register resets to B, so that A wins the first tie.
- IDLE transitions:
  - Only one of a_req/b_req set → that port's OWN state.
  - Both set → the port ≠ last_owner.
  - Neither set → stay in IDLE.
- OWN_A transitions (single-beat grants):
  - After each acked beat: b_req → OWN_B; else a_req → stay; else IDLE.
  - a_req low with no ack → b_req ? OWN_B : IDLE.
- OWN_B transitions (burst grants):
  - beat_cnt clears on entry and increments per b_ack.
  - Burst ends on an acked beat with b_last=1, or when beat_cnt reaches MAX_BURST−1.
  - At burst end: a_req ? OWN_A : (b_req ? stay, with beat_cnt cleared : IDLE).
  - b_req dropping mid-burst without b_last → treat as burst end: a_req ? OWN_A : IDLE.
- last_owner updates on every state entry into OWN_x.

## Timing
- Reset outputs: a_ack=b_ack=0, a_rd=b_rd=0, dm_we=0, dm_addr=dm_wd=dm_wpc=0, dm_width=0, dm_signed=0.
- Reset state: state=IDLE, beat_cnt=0, last_owner=B.
- Reset asserted mid-burst: next cycle is IDLE; no write issued in the reset cycle.
- Latency from IDLE: req in cycle N → ack in N+1.
- A streaming while owner: one access per cycle, ack in the same cycle as req.
- Ownership handover adds no bubble. Example: last A ack in N, B ack possible in N+1.
- Reads: a_rd/b_rd are combinational from dm_rd in the ack cycle.
- Writes: commit at the rising edge ending the ack cycle.
- Simultaneous b_last and MAX_BURST limit: a single burst end.
- beat_cnt width: $clog2(MAX_BURST)+1. It never wraps, because the limit ends the burst first.

## Structure
- dm_arb_pkg holds:
  - state encoding: IDLE=2'd0, OWN_A=2'd1, OWN_B=2'd2.
  - width codes: WORD=2'b00, HALF=2'b01, BYTE=2'b10.
  - port ids: PORT_A=1'b0, PORT_B=1'b1.
- One sub-module, dm_arb_mux: combinational owner-select of the dm_* fields and ack/rd gating.
- The FSM, beat_cnt and last_owner live in dm_arbiter.

## Test plan
- Reset low for 2 cycles with a_req=b_req=1 → all outputs 0. First cycle after release: state IDLE. Next cycle: a_ack=1 (A wins tie).
- A writes word 0x1234_5678 to 0x0000_0010 with a_pc=0x3000 → dm_we=1 and dm_wpc=0x3000 in the ack cycle. A following A read (byte, signed) at 0x13 → a_rd=0x0000_0012.
- B burst of 3 with b_last on beat 3 while a_req is held → b_ack in 3 consecutive cycles, then a_ack the next cycle with no gap.
- MAX_BURST=8, B requests 20 beats, A idle → B re-granted after each 8-beat burst with beat_cnt cleared and no IDLE cycle. A raised at beat 5 → A acked in cycle 9.
- Both ports requesting continuously → single A beat, B burst, single A beat … alternation. No dm_we in cycles where neither ack is high.
- Reset asserted during B beat 2 of a write burst → dm_we=0 in the reset cycle. Memory word unchanged for that beat's address.

Source files
------------

// File: rtl/dm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm_arb_pkg
// Purpose  : Shared encodings for the data-memory arbiter: FSM states,
//            memory access width codes and requester port identifiers.
// Revision : 1.0 - initial release
// ============================================================================
package dm_arb_pkg;

  // Arbiter ownership states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_e;

  // Access width codes as understood by the data memory
  localparam logic [1:0] WORD = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] BYTE = 2'b10;

  // Requester identifiers used for the round-robin history
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage : dm_arb_pkg
`default_nettype wire

// File: rtl/dm_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dm_arbiter_if
// Purpose  : Bundle of the two requester ports (pipeline memory stage and
//            DMA/debug master) plus the single-ported data memory bus.
//            'slave' is the arbiter's view, 'master' the environment's view.
// Revision : 1.0 - initial release
// ============================================================================
interface dm_arbiter_if;

  // Port A: pipeline memory stage
  logic        a_req;
  logic [31:0] a_addr;
  logic [31:0] a_wd;
  logic        a_we;
  logic [1:0]  a_width;
  logic        a_signed;
  logic [31:0] a_pc;
  logic        a_ack;
  logic [31:0] a_rd;

  // Port B: DMA / debug master
  logic        b_req;
  logic [31:0] b_addr;
  logic [31:0] b_wd;
  logic        b_we;
  logic [1:0]  b_width;
  logic        b_signed;
  logic        b_last;
  logic        b_ack;
  logic [31:0] b_rd;

  // Data memory side
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic        dm_we;
  logic [1:0]  dm_width;
  logic        dm_signed;
  logic [31:0] dm_wpc;
  logic [31:0] dm_rd;

  modport slave (
    input  a_req, a_addr, a_wd, a_we, a_width, a_signed, a_pc,
    output a_ack, a_rd,
    input  b_req, b_addr, b_wd, b_we, b_width, b_signed, b_last,
    output b_ack, b_rd,
    output dm_addr, dm_wd, dm_we, dm_width, dm_signed, dm_wpc,
    input  dm_rd
  );

  modport master (
    output a_req, a_addr, a_wd, a_we, a_width, a_signed, a_pc,
    input  a_ack, a_rd,
    output b_req, b_addr, b_wd, b_we, b_width, b_signed, b_last,
    input  b_ack, b_rd,
    input  dm_addr, dm_wd, dm_we, dm_width, dm_signed, dm_wpc,
    output dm_rd
  );

endinterface : dm_arbiter_if
`default_nettype wire

// File: rtl/dm_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : dm_arb_mux
// Purpose  : Combinational owner select. Routes the owning port's fields onto
//            the memory bus, and gates acknowledge, write enable and read data
//            so nothing leaks out while idle or while reset is asserted.
// Revision : 1.0 - initial release
// ============================================================================
module dm_arb_mux
  import dm_arb_pkg::*;
(
  input  logic        en_i,        // low during reset: forces every output to 0
  input  state_e      state_i,

  input  logic        a_req_i,
  input  logic [31:0] a_addr_i,
  input  logic [31:0] a_wd_i,
  input  logic        a_we_i,
  input  logic [1:0]  a_width_i,
  input  logic        a_signed_i,
  input  logic [31:0] a_pc_i,
  output logic        a_ack_o,
  output logic [31:0] a_rd_o,

  input  logic        b_req_i,
  input  logic [31:0] b_addr_i,
  input  logic [31:0] b_wd_i,
  input  logic        b_we_i,
  input  logic [1:0]  b_width_i,
  input  logic        b_signed_i,
  output logic        b_ack_o,
  output logic [31:0] b_rd_o,

  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_wd_o,
  output logic        dm_we_o,
  output logic [1:0]  dm_width_o,
  output logic        dm_signed_o,
  output logic [31:0] dm_wpc_o,
  input  logic [31:0] dm_rd_i
);

  // Select the owner's fields; a write only reaches memory on an acked beat
  always_comb begin
    a_ack_o     = 1'b0;
    b_ack_o     = 1'b0;
    a_rd_o      = '0;
    b_rd_o      = '0;
    dm_addr_o   = '0;
    dm_wd_o     = '0;
    dm_we_o     = 1'b0;
    dm_width_o  = WORD;
    dm_signed_o = 1'b0;
    dm_wpc_o    = '0;
    if (en_i) begin
      case (state_i)
        ST_OWN_A: begin
          a_ack_o     = a_req_i;
          dm_addr_o   = a_addr_i;
          dm_wd_o     = a_wd_i;
          dm_we_o     = a_req_i & a_we_i;
          dm_width_o  = a_width_i;
          dm_signed_o = a_signed_i;
          dm_wpc_o    = a_pc_i;
          a_rd_o      = (a_req_i & ~a_we_i) ? dm_rd_i : '0;
        end
        ST_OWN_B: begin
          b_ack_o     = b_req_i;
          dm_addr_o   = b_addr_i;
          dm_wd_o     = b_wd_i;
          dm_we_o     = b_req_i & b_we_i;
          dm_width_o  = b_width_i;
          dm_signed_o = b_signed_i;
          dm_wpc_o    = '0;           // DMA writes carry no instruction PC
          b_rd_o      = (b_req_i & ~b_we_i) ? dm_rd_i : '0;
        end
        default: ;
      endcase
    end
  end

endmodule : dm_arb_mux
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_arbiter
// Purpose  : Two-requester arbiter for the single-ported data memory.
//            Port A (pipeline) gets single-beat grants, Port B (DMA/debug)
//            gets bursts of up to MAX_BURST beats; ties are resolved
//            round-robin. Handover between owners costs no idle cycle.
// Revision : 1.0 - initial release
// ============================================================================
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  dm_arbiter_if.slave  bus_if
);

  // One extra bit of headroom; the burst limit ends a grant before a wrap
  localparam int                CNT_W     = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic              last_owner_q;
  logic              burst_end;

  // A B beat closes the burst either on b_last or on the beat-count limit
  assign burst_end = bus_if.b_last | (beat_cnt_q == LAST_BEAT);

  // Ownership FSM with beat counter and round-robin history
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      beat_cnt_q   <= '0;
      last_owner_q <= PORT_B;         // so A wins the very first tie
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus_if.a_req && (!bus_if.b_req || last_owner_q == PORT_B)) begin
            state_q      <= ST_OWN_A;
            beat_cnt_q   <= '0;
            last_owner_q <= PORT_A;
          end else if (bus_if.b_req) begin
            state_q      <= ST_OWN_B;
            beat_cnt_q   <= '0;
            last_owner_q <= PORT_B;
          end
        end

        // A holds the memory for one beat at a time; a waiting B goes next
        ST_OWN_A: begin
          if (bus_if.b_req) begin
            state_q      <= ST_OWN_B;
            beat_cnt_q   <= '0;
            last_owner_q <= PORT_B;
          end else if (!bus_if.a_req) begin
            state_q <= ST_IDLE;
          end
        end

        ST_OWN_B: begin
          if (!bus_if.b_req) begin
            // B went quiet mid-burst: treat it as the end of the burst
            if (bus_if.a_req) begin
              state_q      <= ST_OWN_A;
              beat_cnt_q   <= '0;
              last_owner_q <= PORT_A;
            end else begin
              state_q    <= ST_IDLE;
              beat_cnt_q <= '0;
            end
          end else if (burst_end) begin
            if (bus_if.a_req) begin
              state_q      <= ST_OWN_A;
              beat_cnt_q   <= '0;
              last_owner_q <= PORT_A;
            end else begin
              // Nobody else waiting: re-grant B straight away with a fresh count
              beat_cnt_q   <= '0;
              last_owner_q <= PORT_B;
            end
          end else begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          beat_cnt_q <= '0;
        end
      endcase
    end
  end

  dm_arb_mux u_mux (
    .en_i        (rst_ni),
    .state_i     (state_q),
    .a_req_i     (bus_if.a_req),
    .a_addr_i    (bus_if.a_addr),
    .a_wd_i      (bus_if.a_wd),
    .a_we_i      (bus_if.a_we),
    .a_width_i   (bus_if.a_width),
    .a_signed_i  (bus_if.a_signed),
    .a_pc_i      (bus_if.a_pc),
    .a_ack_o     (bus_if.a_ack),
    .a_rd_o      (bus_if.a_rd),
    .b_req_i     (bus_if.b_req),
    .b_addr_i    (bus_if.b_addr),
    .b_wd_i      (bus_if.b_wd),
    .b_we_i      (bus_if.b_we),
    .b_width_i   (bus_if.b_width),
    .b_signed_i  (bus_if.b_signed),
    .b_ack_o     (bus_if.b_ack),
    .b_rd_o      (bus_if.b_rd),
    .dm_addr_o   (bus_if.dm_addr),
    .dm_wd_o     (bus_if.dm_wd),
    .dm_we_o     (bus_if.dm_we),
    .dm_width_o  (bus_if.dm_width),
    .dm_signed_o (bus_if.dm_signed),
    .dm_wpc_o    (bus_if.dm_wpc),
    .dm_rd_i     (bus_if.dm_rd)
  );

endmodule : dm_arbiter
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_arbiter
// Purpose  : Self-checking bench for dm_arbiter. A behavioural memory sits on
//            the dm_* bus; a transaction-level ownership model with its own
//            memory image predicts every output, every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  localparam int MAX_BURST = 8;
  localparam int N_RANDOM  = 3000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dm_arbiter_if bus ();

  dm_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_if (bus.slave)
  );

  // ---------------- memory helpers (little-endian) ----------------
  function automatic logic [31:0] extract(logic [31:0] w, logic [1:0] lo,
                                          logic [1:0] width, logic sgn);
    logic [15:0] h;
    logic [7:0]  b;
    case (width)
      HALF: begin
        h = lo[1] ? w[31:16] : w[15:0];
        return sgn ? {{16{h[15]}}, h} : {16'h0, h};
      end
      BYTE: begin
        b = 8'(w >> (8 * lo));
        return sgn ? {{24{b[7]}}, b} : {24'h0, b};
      end
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [1:0] lo,
                                        logic [31:0] wd, logic [1:0] width);
    logic [31:0] m;
    case (width)
      HALF:    m = 32'h0000_FFFF << (16 * lo[1]);
      BYTE:    m = 32'h0000_00FF << (8 * lo);
      default: m = 32'hFFFF_FFFF;
    endcase
    return (old & ~m) | ((wd << (width == HALF ? 16 * lo[1] : (width == BYTE ? 8 * lo : 0))) & m);
  endfunction

  // Memory attached to the DUT bus
  logic [31:0] mem     [64] = '{default: 32'h0};
  // Memory image maintained by the reference model
  logic [31:0] ref_mem [64] = '{default: 32'h0};

  always_comb bus.dm_rd = extract(mem[bus.dm_addr[7:2]], bus.dm_addr[1:0],
                                  bus.dm_width, bus.dm_signed);

  always @(posedge clk)
    if (bus.dm_we)
      mem[bus.dm_addr[7:2]] <= merge(mem[bus.dm_addr[7:2]], bus.dm_addr[1:0],
                                     bus.dm_wd, bus.dm_width);

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: 0 nobody, 1 port A, 2 port B. beats = B beats served in this grant.
  int owner    = 0;
  int beats    = 0;
  bit prefer_a = 1'b1;

  // Expected acks of the most recent cycle, and a few observed values
  logic        last_ea, last_eb;
  logic        obs_a_ack, obs_b_ack, obs_dm_we;
  logic [31:0] obs_a_rd, obs_wpc;

  task automatic grant_to(int p);
    owner    = p;
    beats    = 0;
    prefer_a = (p == 2);
  endtask

  // One clock: check outputs mid-cycle, advance the model, move past the edge
  task automatic step();
    logic        ea, eb, e_we, e_s;
    logic [31:0] e_addr, e_wd, e_wpc, e_ard, e_brd;
    logic [1:0]  e_w;
    @(negedge clk);
    ea = rst_n && owner == 1 && bus.a_req;
    eb = rst_n && owner == 2 && bus.b_req;
    e_addr = '0; e_wd = '0; e_wpc = '0; e_we = 1'b0; e_w = 2'b00; e_s = 1'b0;
    if (rst_n && owner == 1) begin
      e_addr = bus.a_addr; e_wd = bus.a_wd; e_w = bus.a_width;
      e_s = bus.a_signed; e_wpc = bus.a_pc; e_we = ea && bus.a_we;
    end else if (rst_n && owner == 2) begin
      e_addr = bus.b_addr; e_wd = bus.b_wd; e_w = bus.b_width;
      e_s = bus.b_signed; e_we = eb && bus.b_we;
    end
    e_ard = (ea && !bus.a_we) ? extract(ref_mem[bus.a_addr[7:2]], bus.a_addr[1:0],
                                        bus.a_width, bus.a_signed) : '0;
    e_brd = (eb && !bus.b_we) ? extract(ref_mem[bus.b_addr[7:2]], bus.b_addr[1:0],
                                        bus.b_width, bus.b_signed) : '0;

    check("a_ack",     32'(bus.a_ack),     32'(ea));
    check("b_ack",     32'(bus.b_ack),     32'(eb));
    check("a_rd",      bus.a_rd,           e_ard);
    check("b_rd",      bus.b_rd,           e_brd);
    check("dm_we",     32'(bus.dm_we),     32'(e_we));
    check("dm_addr",   bus.dm_addr,        e_addr);
    check("dm_wd",     bus.dm_wd,          e_wd);
    check("dm_width",  32'(bus.dm_width),  32'(e_w));
    check("dm_signed", 32'(bus.dm_signed), 32'(e_s));
    check("dm_wpc",    bus.dm_wpc,         e_wpc);

    obs_a_ack = bus.a_ack; obs_b_ack = bus.b_ack; obs_dm_we = bus.dm_we;
    obs_a_rd  = bus.a_rd;  obs_wpc   = bus.dm_wpc;
    last_ea   = ea;        last_eb   = eb;

    if (ea && bus.a_we)
      ref_mem[bus.a_addr[7:2]] = merge(ref_mem[bus.a_addr[7:2]], bus.a_addr[1:0], bus.a_wd, bus.a_width);
    if (eb && bus.b_we)
      ref_mem[bus.b_addr[7:2]] = merge(ref_mem[bus.b_addr[7:2]], bus.b_addr[1:0], bus.b_wd, bus.b_width);

    if (!rst_n) begin
      owner = 0; beats = 0; prefer_a = 1'b1;
    end else begin
      case (owner)
        0: begin
          if (bus.a_req && bus.b_req) grant_to(prefer_a ? 1 : 2);
          else if (bus.a_req)         grant_to(1);
          else if (bus.b_req)         grant_to(2);
        end
        1: begin
          if (bus.b_req)       grant_to(2);
          else if (!bus.a_req) owner = 0;
        end
        default: begin
          if (!bus.b_req) begin
            if (bus.a_req) grant_to(1);
            else           owner = 0;
          end else begin
            beats++;
            if (bus.b_last || beats == MAX_BURST) begin
              if (bus.a_req) grant_to(1);
              else           grant_to(2);
            end
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- random request generators ----------------
  function automatic logic [31:0] rand_addr(logic [1:0] width);
    logic [31:0] a;
    a = 32'($urandom_range(0, 255));
    if (width == WORD) a[1:0] = 2'b00;
    if (width == HALF) a[0]   = 1'b0;
    return a;
  endfunction

  task automatic new_a();
    bus.a_req    = 1'b1;
    bus.a_width  = 2'($urandom_range(0, 2));
    bus.a_addr   = rand_addr(bus.a_width);
    bus.a_we     = 1'($urandom);
    bus.a_wd     = $urandom;
    bus.a_signed = 1'($urandom);
    bus.a_pc     = $urandom;
  endtask

  task automatic new_b();
    bus.b_req    = 1'b1;
    bus.b_width  = 2'($urandom_range(0, 2));
    bus.b_addr   = rand_addr(bus.b_width);
    bus.b_we     = 1'($urandom);
    bus.b_wd     = $urandom;
    bus.b_signed = 1'($urandom);
    bus.b_last   = ($urandom_range(0, 5) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rst_hold;
    rst_hold = 0;

    // Reset with both ports requesting: A writes, B reads
    rst_n = 1'b0;
    bus.a_req = 1'b1; bus.a_addr = 32'h0000_0010; bus.a_wd = 32'h1234_5678;
    bus.a_we = 1'b1; bus.a_width = WORD; bus.a_signed = 1'b0; bus.a_pc = 32'h0000_3000;
    bus.b_req = 1'b1; bus.b_addr = 32'h0000_0040; bus.b_wd = 32'h0;
    bus.b_we = 1'b0; bus.b_width = WORD; bus.b_signed = 1'b0; bus.b_last = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();                                   // IDLE cycle after release
    check("idle_no_a_ack", 32'(obs_a_ack), 32'h0);
    step();                                   // A wins the tie and writes
    check("tie_a_wins", 32'(obs_a_ack), 32'h1);
    check("write_we",   32'(obs_dm_we), 32'h1);
    check("write_wpc",  obs_wpc,        32'h0000_3000);
    bus.a_addr = 32'h0000_0013; bus.a_we = 1'b0; bus.a_width = BYTE; bus.a_signed = 1'b1;
    step();                                   // B gets its turn (single-beat burst)
    check("b_turn", 32'(obs_b_ack), 32'h1);
    bus.b_req = 1'b0;
    step();                                   // A signed byte read
    check("byte_load", obs_a_rd, 32'h0000_0012);
    bus.a_req = 1'b0;
    step();

    // Randomized traffic with occasional resets
    for (int i = 0; i < N_RANDOM; i++) begin
      if (!rst_n) begin
        rst_hold--;
        if (rst_hold <= 0) rst_n = 1'b1;
      end else if ($urandom_range(0, 79) == 0) begin
        rst_n    = 1'b0;
        rst_hold = $urandom_range(1, 2);
      end
      // Requests stay put until acked; afterwards maybe issue a new one
      if (!bus.a_req || last_ea) begin
        if ($urandom_range(0, 3) != 0) new_a();
        else bus.a_req = 1'b0;
      end
      if (!bus.b_req || last_eb) begin
        if ($urandom_range(0, 7) != 0) new_b();
        else bus.b_req = 1'b0;
      end
      step();
    end

    // Reset in the middle of a B write burst: that beat must not land
    rst_n = 1'b1;
    bus.a_req = 1'b0;
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_width = WORD; bus.b_last = 1'b0;
    bus.b_addr = 32'h0000_0080; bus.b_wd = 32'hAAAA_0001;
    step();
    while (owner != 2) begin
      bus.b_req = 1'b0;
      step();
      bus.b_req = 1'b1;
      step();
    end
    step();                                   // beat 1
    bus.b_addr = 32'h0000_0084; bus.b_wd = 32'hBBBB_0002;
    rst_n = 1'b0;
    step();                                   // beat 2 collides with reset
    check("rst_mid_burst_we", 32'(obs_dm_we), 32'h0);
    rst_n = 1'b1;
    bus.b_req = 1'b0;
    step();
    check("rst_mid_burst_mem", mem[6'h21], ref_mem[6'h21]);

    for (int k = 0; k < 64; k++) check("mem_image", mem[k], ref_mem[k]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_dm_arbiter
`default_nettype wire
